exp5_unidade_controle: RTL and testbench

EXP5_UNIDADE_CONTROLE -- requirements
Module: exp5_unidade_controle

---
 rtl/exp5_unidade_controle.sv | 81 ++++++++
 tb/tb_exp5_unidade_controle.sv | 105 ++++++++++
 2 files changed

// File: rtl/exp5_unidade_controle.sv
// exp5_unidade_controle: Moore control FSM for the memory game, with a play timeout in ESPERA.
module exp5_unidade_controle #(
  parameter int TIMEOUT_CICLOS = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimE,
  input  logic       fimL,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);
  localparam int TW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [TW-1:0] LIMITE = TW'(TIMEOUT_CICLOS - 1);
  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    NOVA_RODADA = 4'h2,
    ESPERA      = 4'h3,
    REGISTRA    = 4'h4,
    COMPARA     = 4'h5,
    PROX_JOGADA = 4'h6,
    PROX_RODADA = 4'h7,
    FIM_ACERTO  = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERRO    = 4'hE
  } estado_t;
  estado_t r_estado, w_prox;
  logic [TW-1:0] r_timer;
  logic w_esgotado;
  assign w_esgotado = (r_timer == LIMITE);
  // Timer only runs while waiting for a play; any other state restarts it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= INICIAL;
      r_timer  <= '0;
    end else begin
      r_estado <= w_prox;
      r_timer  <= (r_estado == ESPERA) ? r_timer + 1'b1 : '0;
    end
  end
  always_comb begin
    w_prox = INICIAL;
    case (r_estado)
      INICIAL:     w_prox = iniciar ? PREPARA : INICIAL;
      PREPARA:     w_prox = NOVA_RODADA;
      NOVA_RODADA: w_prox = ESPERA;
      ESPERA:      w_prox = jogada ? REGISTRA : (w_esgotado ? FIM_TIMEOUT : ESPERA);
      REGISTRA:    w_prox = COMPARA;
      COMPARA:     w_prox = !igual ? FIM_ERRO : (!fimE ? PROX_JOGADA : (fimL ? FIM_ACERTO : PROX_RODADA));
      PROX_JOGADA: w_prox = ESPERA;
      PROX_RODADA: w_prox = NOVA_RODADA;
      FIM_ACERTO:  w_prox = iniciar ? PREPARA : FIM_ACERTO;
      FIM_ERRO:    w_prox = iniciar ? PREPARA : FIM_ERRO;
      FIM_TIMEOUT: w_prox = iniciar ? PREPARA : FIM_TIMEOUT;
      default:     w_prox = INICIAL;
    endcase
  end
  assign zeraE     = (r_estado == PREPARA) || (r_estado == NOVA_RODADA);
  assign contaE    = (r_estado == PROX_JOGADA);
  assign zeraL     = (r_estado == PREPARA);
  assign contaL    = (r_estado == PROX_RODADA);
  assign zeraR     = (r_estado == PREPARA);
  assign registraR = (r_estado == REGISTRA);
  assign acertou   = (r_estado == FIM_ACERTO);
  assign errou     = (r_estado == FIM_ERRO);
  assign timeout   = (r_estado == FIM_TIMEOUT);
  assign pronto    = acertou || errou || timeout;
  assign db_estado = r_estado;
endmodule

// File: tb/tb_exp5_unidade_controle.sv
// tb_exp5_unidade_controle: table-driven check of the game FSM with a small timeout.
module tb_exp5_unidade_controle;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic iniciar = 1'b0, jogada = 1'b0, igual = 1'b0, fimE = 1'b0, fimL = 1'b0;
  logic zeraE, contaE, zeraL, contaL, zeraR, registraR, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct packed {
    logic ini, jog, igu, fe, fl;
    logic [3:0] st;
  } vec_t;
  typedef struct packed {
    logic [3:0] st;
    logic [9:0] o;
  } exp_t;
  vec_t vecs[$];
  exp_t sb[$];
  exp5_unidade_controle #(.TIMEOUT_CICLOS(8)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .igual(igual),
    .fimE(fimE), .fimL(fimL), .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL),
    .contaL(contaL), .zeraR(zeraR), .registraR(registraR), .pronto(pronto),
    .acertou(acertou), .errou(errou), .timeout(timeout), .db_estado(db_estado)
  );
  always #5 clock = ~clock;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  // Expected Moore outputs {zeraE,contaE,zeraL,contaL,zeraR,registraR,pronto,acertou,errou,timeout}.
  function automatic logic [9:0] exp_outs(input logic [3:0] s);
    exp_outs = {s == 4'h1 || s == 4'h2, s == 4'h6, s == 4'h1, s == 4'h7, s == 4'h1,
                s == 4'h4, s == 4'hA || s == 4'hD || s == 4'hE, s == 4'hA, s == 4'hE, s == 4'hD};
  endfunction
  function automatic logic [9:0] outs();
    outs = {zeraE, contaE, zeraL, contaL, zeraR, registraR, pronto, acertou, errou, timeout};
  endfunction
  function automatic void add(input logic ini, jog, igu, fe, fl, input logic [3:0] st);
    vecs.push_back({ini, jog, igu, fe, fl, st});
  endfunction
  task automatic check(input string name, input logic [9:0] got, input logic [9:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask
  task automatic run_vec(input int i, input vec_t v);
    exp_t e;
    {iniciar, jogada, igual, fimE, fimL} = {v.ini, v.jog, v.igu, v.fe, v.fl};
    sb.push_back({v.st, exp_outs(v.st)});
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check($sformatf("row%0d_state", i), {6'd0, db_estado}, {6'd0, e.st});
    check($sformatf("row%0d_outs", i), outs(), e.o);
  endtask
  initial begin
    add(1,0,0,0,0,4'h1); add(0,0,0,0,0,4'h2); add(0,0,0,0,0,4'h3);
    add(0,1,0,0,0,4'h4); add(0,0,0,0,0,4'h5); add(0,0,1,1,0,4'h7);
    add(0,0,0,0,0,4'h2); add(0,0,0,0,0,4'h3);
    add(0,1,0,0,0,4'h4); add(0,0,0,0,0,4'h5); add(0,0,1,0,0,4'h6);
    add(0,0,0,0,0,4'h3); add(1,0,0,0,0,4'h3);
    add(0,1,0,0,0,4'h4); add(0,0,0,0,0,4'h5); add(0,0,0,1,1,4'hE);
    add(0,0,0,0,0,4'hE); add(1,0,0,0,0,4'h1); add(0,0,0,0,0,4'h2); add(0,0,0,0,0,4'h3);
    add(0,1,0,0,0,4'h4); add(0,0,0,0,0,4'h5); add(0,0,1,1,1,4'hA);
    add(0,0,0,0,0,4'hA); add(1,0,0,0,0,4'h1); add(0,0,0,0,0,4'h2); add(0,0,0,0,0,4'h3);
    for (int k = 0; k < 7; k++) add(0,0,0,0,0,4'h3);
    add(0,0,0,0,0,4'hD); add(0,0,0,0,0,4'hD);
    add(1,0,0,0,0,4'h1); add(0,0,0,0,0,4'h2); add(0,0,0,0,0,4'h3);
    for (int k = 0; k < 7; k++) add(0,0,0,0,0,4'h3);
    add(0,1,0,0,0,4'h4); add(0,0,0,0,0,4'h5);
    // Held in reset: iniciar must not move the FSM and every output stays low.
    iniciar = 1'b1;
    #1;
    check("reset_state", {6'd0, db_estado}, 10'd0);
    check("reset_outs", outs(), 10'd0);
    @(posedge clock);
    #1;
    check("reset_hold_state", {6'd0, db_estado}, 10'd0);
    iniciar = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("idle_no_iniciar", {6'd0, db_estado}, 10'd0);
    foreach (vecs[i]) run_vec(i, vecs[i]);
    // Asynchronous reset while in COMPARA must act before the next clock edge.
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_state", {6'd0, db_estado}, 10'd0);
    check("async_rst_outs", outs(), 10'd0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("post_rst_idle", {6'd0, db_estado}, 10'd0);
    run_vec(999, {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h1});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
